cpu16_mem_responder: RTL and testbench

//  Bus responder (target side) for the CPU16 memory interface.
//  - Decodes CPU addresses into ROM, RAM and memory-mapped I/O, and answers each access with a req/ack handshake.
//  - Feeds a small FIFO that queues video commands toward the display/game logic.
//  - Replaces the fixed RAM wait-state counting inside the CPU.

---
 rtl/cpu16_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_cpu16_mem_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu16_mem_responder.sv
// CPU16 bus target: ROM, RAM, STATUS/VIDCMD/TICK registers and a video command FIFO.
// Build option FIFO_DROP_EN: VIDCMD writes to a full FIFO are dropped (sticky overflow) instead of stalling.
`timescale 1ns/1ps
module cpu16_mem_responder #(
   parameter int    ROM_AW     = 10,
   parameter int    RAM_AW     = 10,
   parameter string ROM_FILE   = "rom.hex",
   parameter int    FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_write,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,
   output logic [15:0] vid_data,
   output logic        vid_valid,
   input  logic        vid_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_STALL, ACK} state_t;

   state_t            state, state_nxt;
   logic              reset_meta, rst_n;
   logic [15:0]       rom_mem [2**ROM_AW];
   logic [15:0]       ram_mem [2**RAM_AW];
   logic [15:0]       ram_rdata_p1;
   logic [15:0]       wdata_q;
   logic [15:0]       tick;
   logic [15:0]       rd_mux;
   logic [15:0]       status_word;
   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop, can_push;
   logic [15:0]       fifo_wdata;
   logic              overflow;
   logic              sample, vid_cmd_wr;
   logic              is_rom, is_ram, is_status, is_vidcmd, is_tick;

   // Asynchronous assertion, release synchronised to clk through two flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reset_meta <= 1'b0;
         rst_n      <= 1'b0;
      end else begin
         reset_meta <= 1'b1;
         rst_n      <= reset_meta;
      end
   end

   assign is_rom    = (cpu_addr[15:14] == 2'b00);
   assign is_ram    = (cpu_addr[15:14] == 2'b01);
   assign is_status = (cpu_addr == 16'h8000);
   assign is_vidcmd = (cpu_addr == 16'h8001);
   assign is_tick   = (cpu_addr == 16'h8002);

   assign sample     = rst_n && (state == IDLE) && cpu_req;
   assign vid_cmd_wr = sample && cpu_write && is_vidcmd;

   assign fifo_full  = (fifo_count == FULL_CNT);
   assign fifo_empty = (fifo_count == '0);
   assign fifo_pop   = !fifo_empty && vid_ready;
   // A pop in the same edge frees the slot the push needs.
   assign can_push   = !fifo_full || fifo_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               if (!cpu_write && is_ram)
                  state_nxt = RD_WAIT;
`ifdef FIFO_DROP_EN
               else
                  state_nxt = ACK;
`else
               else if (cpu_write && is_vidcmd && !can_push)
                  state_nxt = WR_STALL;
               else
                  state_nxt = ACK;
`endif
            end
         end
         RD_WAIT:  state_nxt = ACK;
         WR_STALL: if (can_push) state_nxt = ACK;
         ACK:      state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cpu_ack    = (state == ACK);
      fifo_push  = 1'b0;
      fifo_wdata = cpu_wdata;
      case (state)
         IDLE:     fifo_push = vid_cmd_wr && can_push;
         WR_STALL: begin
            fifo_push  = can_push;
            fifo_wdata = wdata_q;
         end
         default:  fifo_push = 1'b0;
      endcase
   end

`ifdef FIFO_DROP_EN
   logic overflow_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow_q <= 1'b0;
      else if (vid_cmd_wr && !can_push)
         overflow_q <= 1'b1;
      else if (sample && !cpu_write && is_status)
         overflow_q <= 1'b0;
   end
   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   assign status_word = {overflow, fifo_full, fifo_empty, 9'b0, 4'(fifo_count)};

   always_comb begin
      rd_mux = 16'h0000;
      if (is_rom)         rd_mux = rom_mem[cpu_addr[ROM_AW-1:0]];
      else if (is_status) rd_mux = status_word;
      else if (is_tick)   rd_mux = tick;
   end

   // Read data is captured only on the way into ACK and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cpu_rdata <= 16'h0000;
      else if (sample && !cpu_write && !is_ram)
         cpu_rdata <= rd_mux;
      else if (state == RD_WAIT)
         cpu_rdata <= ram_rdata_p1;
   end

   always_ff @(posedge clk) begin
      if (sample && is_ram) begin
         if (cpu_write) ram_mem[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
         else           ram_rdata_p1 <= ram_mem[cpu_addr[RAM_AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE) wdata_q <= cpu_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick <= 16'h0000;
      else        tick <= tick + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr] <= fifo_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign vid_valid = !fifo_empty;
   assign vid_data  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_cpu16_mem_responder.sv
// Directed bench for cpu16_mem_responder: ROM/RAM/I-O decode, handshake latency, FIFO full/stall/drop, reset.
`timescale 1ns/1ps
module tb_cpu16_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_write;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;
   logic [15:0] vid_data;
   logic        vid_valid;
   logic        vid_ready;

   int checks = 0;
   int errors = 0;

   cpu16_mem_responder #(
      .ROM_AW    (10),
      .RAM_AW    (10),
      .ROM_FILE  (""),
      .FIFO_DEPTH(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .vid_ready (vid_ready)
   );

   always #5 clk = ~clk;

   // Called at a negedge with the responder idle; returns at a negedge with it idle again.
   // lat counts posedges from the sampling edge until ack is seen (20 = no ack).
   task automatic bus_access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                             output logic [15:0] rd, output int lat);
      cpu_req   = 1'b1;
      cpu_write = wr;
      cpu_addr  = addr;
      cpu_wdata = wd;
      lat = 0;
      @(posedge clk);
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (cpu_ack) break;
      end
      rd = cpu_rdata;
      cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Internal release synchroniser holds the design in reset for two more edges.
   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      int lat;
      reset = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0;
      cpu_addr = 16'h0; cpu_wdata = 16'h0; vid_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_bus: ack=%b rdata=%h required ack=0 rdata=0000", cpu_ack, cpu_rdata);
      end
      checks++;
      if (vid_valid !== 1'b0 || vid_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_fifo: valid=%b data=%h required valid=0 data=0000", vid_valid, vid_data);
      end
      release_reset();
      bus_access(1'b0, 16'h8000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h2000 || lat != 1) begin
         errors++;
         $display("FAIL reset_status: rdata=%h lat=%0d required 2000 lat=1", rd, lat);
      end
   endtask

   task automatic test_rom_read();
      logic [15:0] rd;
      int lat;
      bus_access(1'b0, 16'h0005, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hBEEF || lat != 1) begin
         errors++;
         $display("FAIL rom_read: rdata=%h lat=%0d required BEEF lat=1", rd, lat);
      end
   endtask

   task automatic test_ram();
      logic [15:0] rd;
      int lat;
      bus_access(1'b1, 16'h4010, 16'h1234, rd, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL ram_write_lat: lat=%0d required 1", lat);
      end
      bus_access(1'b0, 16'h4010, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h1234 || lat != 2) begin
         errors++;
         $display("FAIL ram_read: rdata=%h lat=%0d required 1234 lat=2", rd, lat);
      end
   endtask

   task automatic test_fifo_full();
      logic [15:0] rd;
      int lat;
      logic ack_seen;
      vid_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_access(1'b1, 16'h8001, 16'h00A0 + 16'(i), rd, lat);
         checks++;
         if (lat != 1) begin
            errors++;
            $display("FAIL vid_push_lat[%0d]: lat=%0d required 1", i, lat);
         end
      end
      bus_access(1'b0, 16'h8000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h4004) begin
         errors++;
         $display("FAIL status_full: rdata=%h required 4004", rd);
      end
`ifdef FIFO_DROP_EN
      bus_access(1'b1, 16'h8001, 16'h00A4, rd, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL drop_lat: lat=%0d required 1", lat);
      end
      bus_access(1'b0, 16'h8000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hC004) begin
         errors++;
         $display("FAIL status_overflow: rdata=%h required C004", rd);
      end
      bus_access(1'b0, 16'h8000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h4004) begin
         errors++;
         $display("FAIL status_overflow_clear: rdata=%h required 4004", rd);
      end
      vid_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vid_valid !== 1'b1 || vid_data !== 16'h00A0 + 16'(i)) begin
            errors++;
            $display("FAIL drop_order[%0d]: valid=%b data=%h required %h", i, vid_valid, vid_data, 16'h00A0 + 16'(i));
         end
         @(posedge clk);
         @(negedge clk);
      end
`else
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h8001; cpu_wdata = 16'h00A4;
      ack_seen = 1'b0;
      @(posedge clk);
      repeat (6) begin
         @(negedge clk);
         if (cpu_ack) ack_seen = 1'b1;
      end
      checks++;
      if (ack_seen !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_ack: ack seen while FIFO full, required none");
      end
      vid_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vid_ready = 1'b0;
      checks++;
      if (cpu_ack !== 1'b1 || vid_data !== 16'h00A1) begin
         errors++;
         $display("FAIL stall_release: ack=%b head=%h required ack=1 head=00A1", cpu_ack, vid_data);
      end
      cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vid_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (vid_valid !== 1'b1 || vid_data !== 16'h00A0 + 16'(i)) begin
            errors++;
            $display("FAIL stall_order[%0d]: valid=%b data=%h required %h", i, vid_valid, vid_data, 16'h00A0 + 16'(i));
         end
         @(posedge clk);
         @(negedge clk);
      end
`endif
      vid_ready = 1'b0;
      checks++;
      if (vid_valid !== 1'b0 || vid_data !== 16'h0000) begin
         errors++;
         $display("FAIL fifo_drained: valid=%b data=%h required valid=0 data=0000", vid_valid, vid_data);
      end
   endtask

   task automatic test_push_pop();
      logic [15:0] rd;
      int lat;
      vid_ready = 1'b0;
      bus_access(1'b1, 16'h8001, 16'h00B0, rd, lat);
      bus_access(1'b1, 16'h8001, 16'h00B1, rd, lat);
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h8001; cpu_wdata = 16'h00B2;
      vid_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vid_ready = 1'b0;
      checks++;
      if (cpu_ack !== 1'b1 || vid_data !== 16'h00B1) begin
         errors++;
         $display("FAIL push_pop_ack: ack=%b head=%h required ack=1 head=00B1", cpu_ack, vid_data);
      end
      cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus_access(1'b0, 16'h8000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0002) begin
         errors++;
         $display("FAIL push_pop_count: status=%h required 0002", rd);
      end
      vid_ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (vid_valid !== 1'b1 || vid_data !== 16'h00B0 + 16'(i)) begin
            errors++;
            $display("FAIL push_pop_order[%0d]: valid=%b data=%h required %h", i, vid_valid, vid_data, 16'h00B0 + 16'(i));
         end
         @(posedge clk);
         @(negedge clk);
      end
      vid_ready = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      logic [15:0] rd;
      int lat;
      logic ack_seen;
      bus_access(1'b1, 16'h4020, 16'h5A5A, rd, lat);
      bus_access(1'b1, 16'h8001, 16'h00C0, rd, lat);
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h4020;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cpu_req = 1'b0;
      ack_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (cpu_ack) ack_seen = 1'b1;
      end
      checks++;
      if (ack_seen !== 1'b0 || cpu_rdata !== 16'h0000) begin
         errors++;
         $display("FAIL abort_no_ack: ack_seen=%b rdata=%h required 0 0000", ack_seen, cpu_rdata);
      end
      checks++;
      if (vid_valid !== 1'b0 || vid_data !== 16'h0000) begin
         errors++;
         $display("FAIL abort_fifo: valid=%b data=%h required valid=0 data=0000", vid_valid, vid_data);
      end
      release_reset();
      bus_access(1'b0, 16'h8002, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0000 || lat != 1) begin
         errors++;
         $display("FAIL abort_tick: tick=%h lat=%0d required 0000 lat=1", rd, lat);
      end
      bus_access(1'b0, 16'h4020, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h5A5A || lat != 2) begin
         errors++;
         $display("FAIL abort_ram_kept: rdata=%h lat=%0d required 5A5A lat=2", rd, lat);
      end
   endtask

   task automatic test_misc();
      logic [15:0] rd;
      int lat;
      bus_access(1'b0, 16'h9000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0000 || lat != 1) begin
         errors++;
         $display("FAIL unmapped_read: rdata=%h lat=%0d required 0000 lat=1", rd, lat);
      end
      bus_access(1'b1, 16'h0005, 16'h1111, rd, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL rom_write_ack: lat=%0d required 1", lat);
      end
      bus_access(1'b0, 16'h0005, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hBEEF) begin
         errors++;
         $display("FAIL rom_unchanged: rdata=%h required BEEF", rd);
      end
      bus_access(1'b0, 16'h8001, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0000) begin
         errors++;
         $display("FAIL vidcmd_read: rdata=%h required 0000", rd);
      end
   endtask

   task automatic test_tick_wrap();
      logic [15:0] rd;
      int lat;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      release_reset();
      // First sampling edge after release reads 0, so 65535 edges later reads FFFF.
      repeat (65535) @(posedge clk);
      @(negedge clk);
      bus_access(1'b0, 16'h8002, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hFFFF) begin
         errors++;
         $display("FAIL tick_max: tick=%h required FFFF", rd);
      end
      bus_access(1'b0, 16'h8002, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0001) begin
         errors++;
         $display("FAIL tick_wrap: tick=%h required 0001", rd);
      end
   endtask

   initial begin
      dut.rom_mem[5] = 16'hBEEF;
      test_reset();
      test_rom_read();
      test_ram();
      test_fifo_full();
      test_push_pop();
      test_reset_mid_access();
      test_misc();
      test_tick_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
